// File: rtl/car_scheduler_pkg.sv
// Shared definitions for the car scheduler: FSM encoding, sprite geometry and
// the fixed lane row table used by the collision check.
package car_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    NEXT,
    CHECK,
    DONE
  } state_t;

  localparam int CAR_W  = 8;
  localparam int CAR_H  = 4;
  localparam int FROG_W = 4;
  localparam int FROG_H = 4;

  localparam logic [6:0] LANE_Y [4] = '{7'd90, 7'd70, 7'd50, 7'd30};

  // Lanes repeat every four cars when more engines than table rows are built.
  function automatic logic [6:0] lane_y(input int unsigned car);
    logic [1:0] sel;
    sel = car[1:0];
    return LANE_Y[sel];
  endfunction

endpackage

// File: rtl/car_scheduler_if.sv
// Arbitrated pixel stream from the scheduler towards the VGA adapter.
interface car_scheduler_if;

  logic       vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  modport master (output vga_plot, vga_x, vga_y, vga_colour);
  modport slave  (input  vga_plot, vga_x, vga_y, vga_colour);

endinterface

// File: rtl/car_overlap.sv
// Combinational bounding-box test between the frog sprite and one car sprite.
// Operands are widened by one bit so edge sums never wrap.
module car_overlap
  import car_scheduler_pkg::*;
(
  input  logic [7:0] frog_x,
  input  logic [6:0] frog_y,
  input  logic [7:0] x_ori,
  input  logic [6:0] lane,
  output logic       overlap
);

  logic [8:0] fx, cx;
  logic [7:0] fy, cy;

  assign fx = {1'b0, frog_x};
  assign cx = {1'b0, x_ori};
  assign fy = {1'b0, frog_y};
  assign cy = {1'b0, lane};

  assign overlap = (fx <= cx + 9'(CAR_W - 1))  &&
                   (fx + 9'(FROG_W - 1) >= cx) &&
                   (fy <= cy + 8'(CAR_H - 1))  &&
                   (fy + 8'(FROG_H - 1) >= cy);

endmodule

// File: rtl/car_scheduler.sv
// Sequences the car sprite engines one at a time, muxes the active car's pixels
// onto the VGA stream and checks frog/car collisions once per round.
module car_scheduler
  import car_scheduler_pkg::*;
#(
  parameter int          NUM_CARS = 4,
  parameter logic [19:0] TIMEOUT  = 20'd100000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [NUM_CARS-1:0]   car_finish,
  input  logic [NUM_CARS-1:0]   car_plot,
  input  logic [8*NUM_CARS-1:0] car_x,
  input  logic [7*NUM_CARS-1:0] car_y,
  input  logic [3*NUM_CARS-1:0] car_colour,
  input  logic [8*NUM_CARS-1:0] car_x_ori,
  input  logic [7:0]            frog_x,
  input  logic [6:0]            frog_y,
  input  logic                  clear_hit,
  output logic [NUM_CARS-1:0]   car_en,
  car_scheduler_if.master       vga,
  output logic                  round_done,
  output logic                  hit,
  output logic                  timeout_err
);

  localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [19:0]         busy_cnt;
  logic [NUM_CARS-1:0] overlap;
  logic                sel_finish;
  logic                cnt_expired;

  assign sel_finish  = car_finish[idx];
  assign cnt_expired = (busy_cnt == TIMEOUT - 20'd1);

  for (genvar i = 0; i < NUM_CARS; i++) begin : g_overlap
    car_overlap u_overlap (
      .frog_x  (frog_x),
      .frog_y  (frog_y),
      .x_ori   (car_x_ori[8*i +: 8]),
      .lane    (lane_y(i)),
      .overlap (overlap[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    car_en     = '0;
    round_done = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE: begin
        car_en[idx] = 1'b1;
        state_nxt   = BUSY;
      end
      BUSY:    if (sel_finish || cnt_expired) state_nxt = NEXT;
      NEXT:    state_nxt = (idx == LAST_IDX) ? CHECK : ISSUE;
      CHECK:   state_nxt = DONE;
      DONE: begin
        round_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A real finish in the same cycle as the deadline is not an error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx         <= '0;
      busy_cnt    <= '0;
      hit         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE:  idx      <= '0;
        ISSUE: busy_cnt <= '0;
        BUSY: begin
          busy_cnt <= busy_cnt + 20'd1;
          if (!sel_finish && cnt_expired) timeout_err <= 1'b1;
        end
        NEXT:  if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        default: ;
      endcase
      if (state == CHECK && |overlap) hit <= 1'b1;
      else if (clear_hit)             hit <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || state != BUSY) begin
      vga.vga_plot   <= 1'b0;
      vga.vga_x      <= '0;
      vga.vga_y      <= '0;
      vga.vga_colour <= '0;
    end else begin
      vga.vga_plot   <= car_plot[idx];
      vga.vga_x      <= car_x[idx*8 +: 8];
      vga.vga_y      <= car_y[idx*7 +: 7];
      vga.vga_colour <= car_colour[idx*3 +: 3];
    end
  end

endmodule

// File: tb/tb_car_scheduler.sv
// Directed bench for car_scheduler: round sequencing, pixel arbitration,
// collision flag, finish timeout and mid-round reset.
module tb_car_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [3:0]  car_finish;
  logic [3:0]  car_plot;
  logic [31:0] car_x;
  logic [27:0] car_y;
  logic [11:0] car_colour;
  logic [31:0] car_x_ori;
  logic [7:0]  frog_x;
  logic [6:0]  frog_y;
  logic        clear_hit;
  logic [3:0]  car_en;
  logic        round_done;
  logic        hit;
  logic        timeout_err;

  int test_count = 0;
  int fail_count = 0;
  int done_count = 0;
  logic [3:0] en_seen = '0;

  car_scheduler_if vga_bus ();

  car_scheduler #(.NUM_CARS(4), .TIMEOUT(20'd50)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .car_finish  (car_finish),
    .car_plot    (car_plot),
    .car_x       (car_x),
    .car_y       (car_y),
    .car_colour  (car_colour),
    .car_x_ori   (car_x_ori),
    .frog_x      (frog_x),
    .frog_y      (frog_y),
    .clear_hit   (clear_hit),
    .car_en      (car_en),
    .vga         (vga_bus),
    .round_done  (round_done),
    .hit         (hit),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    done_count += int'(round_done);
    en_seen |= car_en;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_for_en(input int i);
    for (int k = 0; k < 100 && car_en === 4'b0000; k++) tick();
    checkOutput($sformatf("car_en_%0d", i), 32'(car_en), 32'(1) << i);
  endtask

  task automatic finish_car(input int i, input int n);
    repeat (n) tick();
    car_finish = 4'(1 << i);
    tick();
    car_finish = '0;
  endtask

  task automatic run_round(input int d);
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      wait_for_en(i);
      finish_car(i, d);
    end
    repeat (6) tick();
  endtask

  task automatic pulse_clear();
    clear_hit = 1'b1;
    tick();
    clear_hit = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] vga_word();
    return 32'({vga_bus.vga_plot, vga_bus.vga_x, vga_bus.vga_y, vga_bus.vga_colour});
  endfunction

  initial begin
    resetn = 1'b0; start = 1'b0; car_finish = '0; car_plot = '0;
    car_x = '0; car_y = '0; car_colour = '0; car_x_ori = {4{8'd200}};
    frog_x = 8'd0; frog_y = 7'd0; clear_hit = 1'b0;
    repeat (2) tick();
    checkOutput("rst_car_en", 32'(car_en), 0);
    checkOutput("rst_vga", vga_word(), 0);
    checkOutput("rst_round_done", 32'(round_done), 0);
    checkOutput("rst_hit", 32'(hit), 0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 0);
    resetn = 1'b1;
    tick();

    // Round 1: ordering, pixel arbitration, foreign finish, ignored start.
    done_count = 0;
    applyStimulus();
    wait_for_en(0);
    tick();
    checkOutput("en_zero_busy", 32'(car_en), 0);
    car_plot = 4'b0011;
    car_x = {16'd0, 8'd40, 8'd12};
    car_y = {14'd0, 7'd70, 7'd33};
    car_colour = {6'd0, 3'b100, 3'b010};
    #1;
    checkOutput("vga_latency", 32'(vga_bus.vga_plot), 0);
    tick();
    checkOutput("vga_car0", vga_word(), 32'({1'b1, 8'd12, 7'd33, 3'b010}));
    car_plot = 4'b0010;
    tick();
    checkOutput("vga_car1_blocked", vga_word(), 32'({1'b0, 8'd12, 7'd33, 3'b010}));
    car_plot = '0; car_x = '0; car_y = '0; car_colour = '0;
    car_finish = 4'b0010;
    start = 1'b1;
    tick();
    car_finish = '0;
    start = 1'b0;
    tick();
    checkOutput("foreign_finish", 32'(car_en), 0);
    finish_car(0, 5);
    for (int i = 1; i < 4; i++) begin
      wait_for_en(i);
      if (i == 3) checkOutput("no_early_done", 32'(done_count), 0);
      finish_car(i, 10);
    end
    repeat (6) tick();
    checkOutput("round_done_once", 32'(done_count), 1);
    en_seen = '0;
    repeat (8) tick();
    checkOutput("start_not_queued", 32'(en_seen), 0);
    checkOutput("vga_idle", vga_word(), 0);

    // Collision rounds.
    frog_x = 8'd30; frog_y = 7'd92; car_x_ori = {8'd200, 8'd200, 8'd200, 8'd27};
    run_round(2);
    checkOutput("hit_frog30", 32'(hit), 1);
    pulse_clear();
    checkOutput("clear_hit", 32'(hit), 0);
    frog_x = 8'd36;
    run_round(2);
    checkOutput("miss_frog36", 32'(hit), 0);
    frog_x = 8'd34;
    run_round(2);
    checkOutput("hit_right_edge", 32'(hit), 1);
    pulse_clear();
    frog_x = 8'd35;
    run_round(2);
    checkOutput("miss_right_edge", 32'(hit), 0);
    frog_x = 8'd255; car_x_ori = {8'd200, 8'd200, 8'd200, 8'd250};
    run_round(2);
    checkOutput("hit_no_wrap", 32'(hit), 1);
    pulse_clear();
    checkOutput("clear_before_set_wins", 32'(hit), 0);

    // clear_hit coinciding with CHECK.
    frog_x = 8'd30; car_x_ori = {8'd200, 8'd200, 8'd200, 8'd27};
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      wait_for_en(i);
      finish_car(i, 2);
    end
    tick();
    clear_hit = 1'b1;
    tick();
    clear_hit = 1'b0;
    checkOutput("set_wins_hit", 32'(hit), 1);
    checkOutput("set_wins_round_done", 32'(round_done), 1);
    pulse_clear();
    checkOutput("late_clear", 32'(hit), 0);

    // Car 2 never finishes.
    frog_x = 8'd0; frog_y = 7'd0;
    done_count = 0;
    applyStimulus();
    wait_for_en(0);
    finish_car(0, 3);
    wait_for_en(1);
    finish_car(1, 3);
    wait_for_en(2);
    repeat (45) tick();
    checkOutput("timeout_not_yet", 32'(timeout_err), 0);
    repeat (6) tick();
    checkOutput("timeout_set", 32'(timeout_err), 1);
    wait_for_en(3);
    finish_car(3, 3);
    repeat (6) tick();
    checkOutput("timeout_round_done", 32'(done_count), 1);
    checkOutput("timeout_sticky", 32'(timeout_err), 1);

    // Reset while car 1 is busy.
    done_count = 0;
    applyStimulus();
    wait_for_en(0);
    finish_car(0, 3);
    wait_for_en(1);
    tick();
    car_plot = 4'b0010; car_x = {16'd0, 8'd40, 8'd0};
    tick();
    checkOutput("pre_reset_vga_plot", 32'(vga_bus.vga_plot), 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    car_plot = '0; car_x = '0;
    checkOutput("mid_rst_car_en", 32'(car_en), 0);
    checkOutput("mid_rst_vga", vga_word(), 0);
    checkOutput("mid_rst_round_done", 32'(round_done), 0);
    checkOutput("mid_rst_timeout_err", 32'(timeout_err), 0);
    en_seen = '0;
    repeat (5) tick();
    checkOutput("mid_rst_no_done", 32'(done_count), 0);
    checkOutput("mid_rst_idle", 32'(en_seen), 0);
    applyStimulus();
    wait_for_en(0);
    finish_car(0, 2);
    for (int i = 1; i < 4; i++) begin
      wait_for_en(i);
      finish_car(i, 2);
    end
    repeat (6) tick();
    checkOutput("restart_round_done", 32'(done_count), 1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
